// File: rtl/io_key_sw_device_pkg.sv
// Shared constants and CTRL-register helpers for the KEY/SW memory-mapped device.
package io_key_sw_device_pkg;

  localparam int KEY_W = 4;
  localparam int SW_W  = 10;

  localparam logic [31:0] ADDR_KDATA = 32'hF000_0010;
  localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;
  localparam logic [31:0] ADDR_SDATA = 32'hF000_0014;
  localparam logic [31:0] ADDR_SCTRL = 32'hF000_0114;

  localparam int CTRL_READY = 0;
  localparam int CTRL_OVRUN = 2;
  localparam int CTRL_IE    = 4;

  typedef struct packed {
    logic ie;
    logic ovr;
    logic ready;
  } ctrl_t;

  // A data update wins over a same-cycle read of the data register, but
  // that read still suppresses the overrun it would otherwise cause.
  function automatic ctrl_t ctrl_next(input ctrl_t cur, input logic wr, input logic wr_ovr,
                                      input logic wr_ie, input logic rd, input logic upd);
    ctrl_t nxt;
    nxt = cur;
    if (wr) begin
      if (!wr_ovr) nxt.ovr = 1'b0;
      nxt.ie = wr_ie;
    end
    if (rd) nxt.ready = 1'b0;
    if (upd) begin
      nxt.ready = 1'b1;
      if (cur.ready && !rd) nxt.ovr = 1'b1;
    end
    return nxt;
  endfunction

  function automatic logic [31:0] ctrl_word(input ctrl_t c);
    logic [31:0] w;
    w             = '0;
    w[CTRL_READY] = c.ready;
    w[CTRL_OVRUN] = c.ovr;
    w[CTRL_IE]    = c.ie;
    return w;
  endfunction

endpackage

// File: rtl/io_key_sw_device_if.sv
// Data-bus port between the MEM stage (master) and the KEY/SW device (slave).
interface io_key_sw_device_if #(
  parameter int DBITS = 32
);
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wrData;
  logic             we;
  logic             re;
  logic             hit;
  logic [DBITS-1:0] rdData;

  modport master (output addr, wrData, we, re, input hit, rdData);
  modport slave  (input addr, wrData, we, re, output hit, rdData);
endinterface

// File: rtl/io_debounce.sv
// Accepts a synchronized input once it has been stable for CYCLES edges;
// upd_o flags the cycle whose closing edge loads the new stable value.
module io_debounce #(
  parameter int WIDTH  = 10,
  parameter int CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sync_i,
  output logic [WIDTH-1:0] stable_o,
  output logic             upd_o
);

  localparam int            CW      = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             upd;

  // Acceptance looks at the next count so CYCLES=1 passes a change straight through.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sync_i != cand_q) begin
      cand_d = sync_i;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    upd      = (cnt_d == CNT_MAX) && (cand_d != stable_q);
    stable_d = upd ? cand_d : stable_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
  assign upd_o    = upd;

endmodule

// File: rtl/io_key_sw_device.sv
// Memory-mapped KEY/SW responder: input sync, SW debounce, DATA/CTRL registers,
// combinational read mux and registered interrupt request.
module io_key_sw_device
  import io_key_sw_device_pkg::*;
#(
  parameter int DBITS           = 32,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [KEY_W-1:0]      KEY,
  input  logic [SW_W-1:0]       SW,
  io_key_sw_device_if.slave     bus,
  output logic                  intr
);

  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wr_data;
  logic [DBITS-1:0] rd_data;

  logic [KEY_W-1:0] key_s1_q, key_s1_d, key_s2_q, key_s2_d;
  logic [SW_W-1:0]  sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [KEY_W-1:0] kdata;
  logic [SW_W-1:0]  sdata;
  logic             key_upd, sw_upd;

  ctrl_t k_ctrl_q, k_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic  intr_q, intr_d;

  logic sel_kd, sel_kc, sel_sd, sel_sc, hit;
  logic unused_wr_bits;

  assign addr    = bus.addr;
  assign wr_data = bus.wrData;

  assign sel_kd = (addr == DBITS'(ADDR_KDATA));
  assign sel_kc = (addr == DBITS'(ADDR_KCTRL));
  assign sel_sd = (addr == DBITS'(ADDR_SDATA));
  assign sel_sc = (addr == DBITS'(ADDR_SCTRL));
  assign hit    = sel_kd | sel_kc | sel_sd | sel_sc;

  assign unused_wr_bits = ^{wr_data[DBITS-1:5], wr_data[3], wr_data[1:0]};

  io_debounce #(.WIDTH(KEY_W), .CYCLES(1)) u_key_db (
    .clk      (clk),
    .reset    (reset),
    .sync_i   (key_s2_q),
    .stable_o (kdata),
    .upd_o    (key_upd)
  );

  io_debounce #(.WIDTH(SW_W), .CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk      (clk),
    .reset    (reset),
    .sync_i   (sw_s2_q),
    .stable_o (sdata),
    .upd_o    (sw_upd)
  );

  always_comb begin
    key_s1_d = ~KEY;
    key_s2_d = key_s1_q;
    sw_s1_d  = SW;
    sw_s2_d  = sw_s1_q;

    k_ctrl_d = ctrl_next(k_ctrl_q, bus.we && sel_kc, wr_data[CTRL_OVRUN], wr_data[CTRL_IE],
                         bus.re && sel_kd, key_upd);
    s_ctrl_d = ctrl_next(s_ctrl_q, bus.we && sel_sc, wr_data[CTRL_OVRUN], wr_data[CTRL_IE],
                         bus.re && sel_sd, sw_upd);

    intr_d = (k_ctrl_q.ready & k_ctrl_q.ie) | (s_ctrl_q.ready & s_ctrl_q.ie);
  end

  // Reads see pre-edge register state, so a same-cycle store is not visible yet.
  always_comb begin
    rd_data = '0;
    if (bus.re) begin
      if (sel_kd)      rd_data = DBITS'(kdata);
      else if (sel_kc) rd_data = DBITS'(ctrl_word(k_ctrl_q));
      else if (sel_sd) rd_data = DBITS'(sdata);
      else if (sel_sc) rd_data = DBITS'(ctrl_word(s_ctrl_q));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_s1_q <= '0;
      key_s2_q <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      k_ctrl_q <= '0;
      s_ctrl_q <= '0;
      intr_q   <= 1'b0;
    end else begin
      key_s1_q <= key_s1_d;
      key_s2_q <= key_s2_d;
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
      k_ctrl_q <= k_ctrl_d;
      s_ctrl_q <= s_ctrl_d;
      intr_q   <= intr_d;
    end
  end

  assign bus.hit    = hit;
  assign bus.rdData = rd_data;
  assign intr       = intr_q;

endmodule

// File: tb/tb_io_key_sw_device.sv
// Directed bench for io_key_sw_device with a short debounce window.
module tb_io_key_sw_device;

  localparam logic [31:0] A_KD = 32'hF000_0010;
  localparam logic [31:0] A_KC = 32'hF000_0110;
  localparam logic [31:0] A_SD = 32'hF000_0014;
  localparam logic [31:0] A_SC = 32'hF000_0114;

  logic       clk;
  logic       reset;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic       intr;

  int n_checks;
  int n_fail;

  io_key_sw_device_if #(.DBITS(32)) bus ();

  io_key_sw_device #(.DBITS(32), .DEBOUNCE_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .KEY   (KEY),
    .SW    (SW),
    .bus   (bus),
    .intr  (intr)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        re;
    logic        exp_hit;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Combinational look at a register: re is dropped before the next edge, so no side effects.
  task automatic peek(input string nm, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    bus.re   = 1'b1;
    #1;
    chk(nm, bus.rdData, exp);
    bus.re = 1'b0;
    #1;
  endtask

  task automatic bus_rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    bus.re   = 1'b1;
    #1;
    chk(nm, bus.rdData, exp);
    chk({nm, "_hit"}, {31'd0, bus.hit}, 32'd1);
    tick();
    bus.re = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr   = a;
    bus.wrData = d;
    bus.we     = 1'b1;
    tick();
    bus.we     = 1'b0;
    bus.wrData = '0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    KEY        = 4'hF;
    SW         = 10'h000;
    bus.addr   = '0;
    bus.wrData = '0;
    bus.we     = 1'b0;
    bus.re     = 1'b0;

    vecs[0] = '{"rst_kdata",  A_KD,          1'b1, 1'b1, 32'h0};
    vecs[1] = '{"rst_kctrl",  A_KC,          1'b1, 1'b1, 32'h0};
    vecs[2] = '{"rst_sdata",  A_SD,          1'b1, 1'b1, 32'h0};
    vecs[3] = '{"rst_sctrl",  A_SC,          1'b1, 1'b1, 32'h0};
    vecs[4] = '{"noread_kd",  A_KD,          1'b0, 1'b1, 32'h0};
    vecs[5] = '{"miss_low",   32'h0000_0010, 1'b1, 1'b0, 32'h0};
    vecs[6] = '{"miss_hi",    32'hF100_0010, 1'b1, 1'b0, 32'h0};
    vecs[7] = '{"miss_next",  32'hF000_0018, 1'b1, 1'b0, 32'h0};
    vecs[8] = '{"miss_odd",   32'hF000_0012, 1'b1, 1'b0, 32'h0};
    vecs[9] = '{"miss_ctrl",  32'hF000_0118, 1'b1, 1'b0, 32'h0};

    repeat (3) tick();
    chk("rst_intr", {31'd0, intr}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      bus.addr = vecs[i].addr;
      bus.re   = vecs[i].re;
      #2;
      chk({vecs[i].name, "_rd"},  bus.rdData, vecs[i].exp_rd);
      chk({vecs[i].name, "_hit"}, {31'd0, bus.hit}, {31'd0, vecs[i].exp_hit});
      bus.re = 1'b0;
      tick();
    end

    // key press: three edges to KDATA, read clears ready
    KEY = 4'b1101;
    repeat (2) tick();
    peek("kd_2edges", A_KD, 32'h0);
    tick();
    peek("kd_3edges", A_KD, 32'h2);
    peek("kc_ready", A_KC, 32'h1);
    bus_rd("kd_read", A_KD, 32'h2);
    peek("kc_after_read", A_KC, 32'h0);

    // overrun and CTRL write semantics
    KEY = 4'hF;
    repeat (3) tick();
    bus_rd("kd_rel", A_KD, 32'h0);
    KEY = 4'b1101;
    repeat (3) tick();
    KEY = 4'b1001;
    repeat (3) tick();
    peek("kc_ovr", A_KC, 32'h5);
    peek("kd_6", A_KD, 32'h6);
    bus_wr(A_KC, 32'h0);
    peek("kc_clr_ovr", A_KC, 32'h1);
    bus_wr(A_KC, 32'h4);
    peek("kc_w1_ign", A_KC, 32'h1);
    bus_wr(A_KD, 32'hF);
    peek("kd_wr_ign", A_KD, 32'h6);
    bus_wr(A_KC, 32'h10);
    chk("kintr_early", {31'd0, intr}, 32'd0);
    peek("kc_ie", A_KC, 32'h11);
    tick();
    chk("kintr_set", {31'd0, intr}, 32'd1);
    bus_rd("kd_rd_intr", A_KD, 32'h6);
    chk("kintr_hold", {31'd0, intr}, 32'd1);
    tick();
    chk("kintr_clr", {31'd0, intr}, 32'd0);
    bus_wr(A_KC, 32'h0);

    // SW glitch rejected, stable value accepted after 2+8 edges
    SW = 10'h155;
    repeat (5) tick();
    SW = 10'h000;
    repeat (20) tick();
    peek("sd_glitch", A_SD, 32'h0);
    peek("sc_glitch", A_SC, 32'h0);
    SW = 10'h155;
    repeat (9) tick();
    peek("sd_9edges", A_SD, 32'h0);
    tick();
    peek("sd_10edges", A_SD, 32'h155);
    peek("sc_ready", A_SC, 32'h1);

    // switch interrupt
    bus_rd("sd_read", A_SD, 32'h155);
    bus_wr(A_SC, 32'h10);
    peek("sc_ie", A_SC, 32'h10);
    SW = 10'h0AA;
    repeat (9) tick();
    peek("sd_old", A_SD, 32'h155);
    tick();
    peek("sd_new", A_SD, 32'h0AA);
    peek("sc_ready_ie", A_SC, 32'h11);
    chk("sintr_early", {31'd0, intr}, 32'd0);
    tick();
    chk("sintr_set", {31'd0, intr}, 32'd1);
    bus_rd("sd_rd_intr", A_SD, 32'h0AA);
    chk("sintr_hold", {31'd0, intr}, 32'd1);
    tick();
    chk("sintr_clr", {31'd0, intr}, 32'd0);

    // reset mid-countdown discards the candidate
    SW = 10'h3C3;
    repeat (6) tick();
    reset = 1'b1;
    #1;
    peek("rst2_sd", A_SD, 32'h0);
    peek("rst2_sc", A_SC, 32'h0);
    peek("rst2_kd", A_KD, 32'h0);
    peek("rst2_kc", A_KC, 32'h0);
    chk("rst2_intr", {31'd0, intr}, 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (9) tick();
    peek("sd_restart9", A_SD, 32'h0);
    tick();
    peek("sd_restart10", A_SD, 32'h3C3);
    peek("sc_restart", A_SC, 32'h1);

    // read coinciding with the update edge: new value, ready kept, no overrun
    SW = 10'h0F0;
    repeat (9) tick();
    bus_rd("sd_rd_upd", A_SD, 32'h3C3);
    peek("sd_after_rdupd", A_SD, 32'h0F0);
    peek("sc_after_rdupd", A_SC, 32'h1);
    reset = 1'b1;
    #1;
    peek("rst3_sd", A_SD, 32'h0);
    peek("rst3_sc", A_SC, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
